// File: rtl/unit_prop_if.sv
// unit_prop_if: push/result bundle between the unit-clause detector, unit_prop_queue and the clause evaluator
// Ports: unit_clause, unit_clause_detected, clear (toward queue); push_ready, assign_valid, assign_lit,
// assigned_mask, value_mask, conflict, overflow, busy (from queue). slave = queue side, master = driver side.
interface unit_prop_if #(
  parameter int WIDTH = 9,
  parameter int NUM_VARS = 64
);
  logic [WIDTH-1:0] unit_clause;
  logic unit_clause_detected;
  logic clear;
  logic push_ready;
  logic assign_valid;
  logic [WIDTH-1:0] assign_lit;
  logic [NUM_VARS-1:0] assigned_mask;
  logic [NUM_VARS-1:0] value_mask;
  logic conflict;
  logic overflow;
  logic busy;
  modport slave (
    input unit_clause, unit_clause_detected, clear,
    output push_ready, assign_valid, assign_lit, assigned_mask, value_mask, conflict, overflow, busy
  );
  modport master (
    output unit_clause, unit_clause_detected, clear,
    input push_ready, assign_valid, assign_lit, assigned_mask, value_mask, conflict, overflow, busy
  );
endinterface

// File: rtl/unit_prop_queue.sv
// unit_prop_queue: buffers detected unit literals in a FIFO and commits them one by one to the assignment table
// Ports: clk, rst (sync, active-high); bus (unit_prop_if.slave) carries push strobe/literal, soft clear,
// push_ready, assign_valid/assign_lit pulse, assigned/value masks, sticky conflict/overflow, busy.
// Optional: define UNIT_DEDUP_EN to drop pushes that exactly match a queued entry or the literal under check.
module unit_prop_queue #(
  parameter int WIDTH = 9,
  parameter int NUM_VARS = 64,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  unit_prop_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ptr_one = 1;
  localparam logic [AW:0] cnt_one = 1;
  localparam logic [AW:0] cnt_full = DEPTH;
  localparam logic [WIDTH-1:0] lit_one = 1;
  localparam logic [WIDTH-1:0] max_var = WIDTH'(NUM_VARS);
  localparam logic [NUM_VARS-1:0] bit_one = 1;
  typedef enum logic [1:0] {IDLE, CHECK, CONFLICT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [WIDTH-1:0] cur_lit, mag;
  logic [NUM_VARS-1:0] onehot;
  logic sign, lit_ok, is_set, set_val, full, dup, do_push, do_pop, commit, ovf;
  assign sign = cur_lit[WIDTH-1];
  assign mag = sign ? -cur_lit : cur_lit;
  assign lit_ok = mag != '0 && mag <= max_var;
  assign onehot = lit_ok ? bit_one << (mag - lit_one) : '0;
  assign is_set = |(bus.assigned_mask & onehot);
  assign set_val = |(bus.value_mask & onehot);
  assign full = count == cnt_full;
  assign bus.push_ready = !full && state != CONFLICT;
  assign bus.busy = count != '0 || state == CHECK;
`ifdef UNIT_DEDUP_EN
  always_comb begin
    dup = state == CHECK && cur_lit == bus.unit_clause;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, AW'(i) - rd_ptr} < count && mem[i] == bus.unit_clause) dup = 1'b1;
  end
`else
  assign dup = 1'b0;
`endif
  // a full FIFO refuses pushes even when a pop happens in the same cycle
  assign do_push = bus.unit_clause_detected && bus.push_ready && !dup;
  assign ovf = bus.unit_clause_detected && state != CONFLICT && full && !dup;
  assign do_pop = state == IDLE && count != '0;
  assign commit = state == CHECK && lit_ok && !is_set;
  always_comb begin
    state_n = state;
    if (do_pop) state_n = CHECK;
    // an assigned variable whose stored value equals the sign bit is the opposite polarity
    if (state == CHECK) state_n = (lit_ok && is_set && set_val == sign) ? CONFLICT : IDLE;
  end
  always_ff @(posedge clk)
    if (do_push && !(rst || bus.clear)) mem[wr_ptr] <= bus.unit_clause;
  always_ff @(posedge clk)
    state <= (rst || bus.clear) ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      cur_lit <= '0;
      bus.assign_valid <= 1'b0;
      bus.assign_lit <= '0;
      bus.assigned_mask <= '0;
      bus.value_mask <= '0;
      bus.conflict <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_one;
      if (do_pop) begin
        cur_lit <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ptr_one;
      end
      if (do_push && !do_pop) count <= count + cnt_one;
      else if (!do_push && do_pop) count <= count - cnt_one;
      bus.assign_valid <= commit;
      if (commit) begin
        bus.assign_lit <= cur_lit;
        bus.assigned_mask <= bus.assigned_mask | onehot;
        bus.value_mask <= bus.value_mask | (sign ? '0 : onehot);
      end
      if (state == CHECK && state_n == CONFLICT) bus.conflict <= 1'b1;
      if (ovf) bus.overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_unit_prop_queue.sv
// tb_unit_prop_queue: vector table plus hand sequences; committed literals checked against a scoreboard queue
module tb_unit_prop_queue;
  logic clk, rst;
  int compared, mismatched, assign_cnt;
  logic [8:0] sb [$];
  unit_prop_if #(.WIDTH(9), .NUM_VARS(64)) bus ();
  unit_prop_queue #(.WIDTH(9), .NUM_VARS(64), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    logic [8:0] lit;
    logic exp_assign;
    logic [63:0] am;
    logic [63:0] vm;
  } vec_t;
  vec_t vecs [8];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.assign_valid === 1'b1) begin
      assign_cnt++;
      if (sb.size() == 0) chk("unexpected_assign", {55'd0, bus.assign_lit}, 64'h1_0000);
      else chk("assign_lit", {55'd0, bus.assign_lit}, {55'd0, sb.pop_front()});
    end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic push(input logic [8:0] l);
    bus.unit_clause = l;
    bus.unit_clause_detected = 1'b1;
    tick();
    bus.unit_clause_detected = 1'b0;
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    sb.delete();
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_am"}, bus.assigned_mask, 64'd0);
    chk({tag, "_vm"}, bus.value_mask, 64'd0);
    chk({tag, "_conflict"}, {63'd0, bus.conflict}, 64'd0);
    chk({tag, "_overflow"}, {63'd0, bus.overflow}, 64'd0);
    chk({tag, "_valid"}, {63'd0, bus.assign_valid}, 64'd0);
    chk({tag, "_lit"}, {55'd0, bus.assign_lit}, 64'd0);
    chk({tag, "_ready"}, {63'd0, bus.push_ready}, 64'd1);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
  endtask
  initial begin
    int base;
    vecs[0] = '{9'd6, 1'b1, 64'h20, 64'h20};
    vecs[1] = '{9'h1FF, 1'b1, 64'h1, 64'h0};
    vecs[2] = '{9'd64, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    vecs[3] = '{9'h1C0, 1'b1, 64'h8000_0000_0000_0000, 64'h0};
    vecs[4] = '{9'd0, 1'b0, 64'h0, 64'h0};
    vecs[5] = '{9'd65, 1'b0, 64'h0, 64'h0};
    vecs[6] = '{9'h100, 1'b0, 64'h0, 64'h0};
    vecs[7] = '{9'h1BF, 1'b0, 64'h0, 64'h0};
    compared = 0;
    mismatched = 0;
    assign_cnt = 0;
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.unit_clause = '0;
    bus.unit_clause_detected = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");
    // latency: pushed at edge E, visible in the cycle after E+2
    sb.push_back(9'd6);
    push(9'd6);
    chk("lat_e0", {63'd0, bus.assign_valid}, 64'd0);
    tick();
    chk("lat_e1", {63'd0, bus.assign_valid}, 64'd0);
    tick();
    chk("lat_e2_valid", {63'd0, bus.assign_valid}, 64'd1);
    chk("lat_e2_am", bus.assigned_mask, 64'h20);
    chk("lat_e2_vm", bus.value_mask, 64'h20);
    for (int i = 0; i < 8; i++) begin
      do_clear();
      if (vecs[i].exp_assign) sb.push_back(vecs[i].lit);
      push(vecs[i].lit);
      repeat (4) tick();
      chk($sformatf("vec%0d_am", i), bus.assigned_mask, vecs[i].am);
      chk($sformatf("vec%0d_vm", i), bus.value_mask, vecs[i].vm);
      chk($sformatf("vec%0d_flags", i), {62'd0, bus.conflict, bus.overflow}, 64'd0);
      chk($sformatf("vec%0d_busy", i), {63'd0, bus.busy}, 64'd0);
      chk($sformatf("vec%0d_sb", i), 64'(sb.size()), 64'd0);
    end
    do_clear();
    sb.push_back(9'd3);
    push(9'd3);
    push(-9'sd3);
    repeat (6) tick();
    chk("conf_flag", {63'd0, bus.conflict}, 64'd1);
    chk("conf_am", bus.assigned_mask, 64'h4);
    chk("conf_vm", bus.value_mask, 64'h4);
    chk("conf_ready", {63'd0, bus.push_ready}, 64'd0);
    push(9'd7);
    repeat (4) tick();
    chk("conf_frozen_am", bus.assigned_mask, 64'h4);
    chk("conf_no_ovf", {63'd0, bus.overflow}, 64'd0);
    chk("conf_sticky", {63'd0, bus.conflict}, 64'd1);
    do_clear();
    check_reset("clear");
    base = assign_cnt;
    sb.push_back(9'd5);
    push(9'd5);
    push(9'd5);
    push(9'd0);
    push(9'd67);
    repeat (12) tick();
    chk("dup_pulses", 64'(assign_cnt - base), 64'd1);
    chk("dup_flags", {62'd0, bus.conflict, bus.overflow}, 64'd0);
    chk("dup_am", bus.assigned_mask, 64'h10);
    do_clear();
    // in 1/cycle, out 1/2 cycles: full after the 15th push, so the 16th is dropped
    for (int i = 1; i <= 16; i++) begin
      if (i <= 15) sb.push_back(9'(i));
      bus.unit_clause = 9'(i);
      bus.unit_clause_detected = 1'b1;
      tick();
      if (i == 15) chk("full_ready", {63'd0, bus.push_ready}, 64'd0);
    end
    bus.unit_clause_detected = 1'b0;
    repeat (40) tick();
    chk("ovf_flag", {63'd0, bus.overflow}, 64'd1);
    chk("ovf_am", bus.assigned_mask, 64'h7FFF);
    chk("ovf_vm", bus.value_mask, 64'h7FFF);
    chk("ovf_sb", 64'(sb.size()), 64'd0);
    do_clear();
    for (int i = 0; i < 8; i++) begin
      if (i < 3) sb.push_back(9'(20 + i));
      push(9'(20 + i));
    end
    chk("mid_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");
    repeat (6) tick();
    chk("midrst_am", bus.assigned_mask, 64'd0);
    chk("midrst_sb", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
